// File: rtl/num_stream_pkg.sv
// Shared types and defaults for the num_stream producer and its checker.
package num_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_STEP      = 2;
  localparam int DEF_MAX_COUNT = 10;
  localparam int CNT_W         = 16;

endpackage

// File: rtl/num_stream_sva.sv
// Concurrent checks on the num_stream_tx output stream; instantiated inside the producer.
module num_stream_sva
  import num_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input logic             clk,
  input logic             reset,
  input logic             valid,
  input logic             ready,
  input logic [WIDTH-1:0] data,
  input logic             done,
  input state_t           state
);

  // A stalled beat must be held; a reset edge is the only legal way out.
  a_hold_on_stall: assert property (@(posedge clk)
    (reset && valid && !ready) |=> ($stable(data) && valid));

  a_done_no_valid: assert property (@(posedge clk) done |-> !valid);

  a_done_single: assert property (@(posedge clk) done |=> !done);

  a_done_is_state: assert property (@(posedge clk) done == (state == DONE));

  generate
    if (STEP % 2 == 0) begin : g_even
      a_even_data: assert property (@(posedge clk) valid |-> !data[0]);
    end
  endgenerate

endmodule

// File: rtl/num_stream_tx.sv
// Valid/ready producer of the sequence 0, STEP, 2*STEP, ... in bursts of MAX_COUNT beats.
module num_stream_tx
  import num_stream_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STEP      = DEF_STEP,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  // Handshake: a beat transfers on any posedge where valid && ready; once
  // raised, valid and data stay put until that transfer happens.

  state_t             state, state_n;
  logic               valid_n;
  logic [WIDTH-1:0]   data_n;
  logic               done_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               stop_pend, pend_n;
  logic               xfer;
  logic               last;
  logic [CNT_W-1:0]   cnt_inc;

  assign xfer    = valid && ready;
  assign cnt_inc = sent_count + CNT_W'(1);
  // A stop arriving in the same cycle as a transfer still makes that beat the last.
  assign last    = (cnt_inc == CNT_W'(MAX_COUNT)) || stop_pend || stop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      valid      <= 1'b0;
      data       <= '0;
      done       <= 1'b0;
      sent_count <= '0;
      stop_pend  <= 1'b0;
    end else begin
      state      <= state_n;
      valid      <= valid_n;
      data       <= data_n;
      done       <= done_n;
      sent_count <= cnt_n;
      stop_pend  <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    valid_n = valid;
    data_n  = data;
    done_n  = 1'b0;
    cnt_n   = sent_count;
    pend_n  = stop_pend;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (start) begin
          state_n = SEND;
          valid_n = 1'b1;
          data_n  = '0;
          cnt_n   = '0;
          pend_n  = 1'b0;
        end
      end
      SEND: begin
        if (stop) pend_n = 1'b1;
        if (xfer) begin
          cnt_n  = cnt_inc;
          data_n = data + WIDTH'(STEP);
          if (last) begin
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  num_stream_sva #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_sva (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .ready (ready),
    .data  (data),
    .done  (done),
    .state (state)
  );

endmodule

// File: tb/tb_num_stream_tx.sv
// Self-checking bench for num_stream_tx: default, wrapping (4-bit, step 6) and single-beat instances.
module tb_num_stream_tx;

  localparam int STEP = 2;
  localparam int MAXC = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start_w, start_o, stop, ready;
  logic        valid, done;
  logic [31:0] data;
  logic [15:0] sent_count;
  logic        valid_w, done_w;
  logic [3:0]  data_w;
  logic [15:0] cnt_w;
  logic        valid_o, done_o;
  logic [31:0] data_o;
  logic [15:0] cnt_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  exp_w_q[$];

  num_stream_tx u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ready(ready),
    .valid(valid), .data(data), .done(done), .sent_count(sent_count)
  );

  num_stream_tx #(.WIDTH(4), .STEP(6), .MAX_COUNT(4)) u_wrap (
    .clk(clk), .reset(reset), .start(start_w), .stop(stop), .ready(ready),
    .valid(valid_w), .data(data_w), .done(done_w), .sent_count(cnt_w)
  );

  num_stream_tx #(.MAX_COUNT(1)) u_one (
    .clk(clk), .reset(reset), .start(start_o), .stop(stop), .ready(ready),
    .valid(valid_o), .data(data_o), .done(done_o), .sent_count(cnt_o)
  );

  // Reference model: beat i of a burst carries i*STEP modulo 2^WIDTH.
  function automatic logic [31:0] beat_value(int i);
    return 32'(i * STEP);
  endfunction

  function automatic logic [3:0] wrap_value(int i);
    int v;
    v = (i * 6) % 16;
    return 4'(v);
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step_cycle();
    step_cycle();
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    total++; if (data !== 32'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", data); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (sent_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", sent_count); end
    total++; if (valid_w !== 1'b0 || valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid_other got=%0b%0b exp=00", valid_w, valid_o); end
    step_cycle();
    reset = 1'b1;
    step_cycle();
  endtask

  task automatic test_basic();
    int beats = 0;
    int dones = 0;
    exp_q.delete();
    for (int i = 0; i < MAXC; i++) exp_q.push_back(beat_value(i));
    ready = 1'b1;
    stop  = 1'b0;
    pulse_start();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < MAXC) begin
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL basic_no_bubble cyc=%0d got=%0b exp=1", c, valid); end
      end
      if (valid && ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL basic_extra_beat got=%0h exp=none", data); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin bad++; $display("FAIL basic_data got=%0h exp=%0h", data, e); end
        end
        beats++;
      end
      if (c == MAXC) begin
        total++; if (done !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL basic_done_slot got=done%0b/valid%0b exp=done1/valid0", done, valid); end
      end
      if (done) dones++;
      step_cycle();
    end
    total++; if (beats != MAXC) begin bad++; $display("FAIL basic_beats got=%0d exp=%0d", beats, MAXC); end
    total++; if (dones != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", dones); end
    total++; if (sent_count !== 16'(MAXC)) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", sent_count, MAXC); end
  endtask

  task automatic test_backpressure();
    int pat[4];
    int beats = 0;
    int dones = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    pat = '{1, 0, 0, 1};
    exp_q.delete();
    for (int i = 0; i < MAXC; i++) exp_q.push_back(beat_value(i));
    pulse_start();
    while (cyc < 200 && dones == 0) begin
      ready = (cyc < 8) ? 1'(pat[cyc % 4]) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (stalled) begin
        total++; if (valid !== 1'b1 || data !== held) begin bad++; $display("FAIL bp_hold got=%0b/%0h exp=1/%0h", valid, data, held); end
      end
      stalled = valid && !ready;
      held = data;
      if (valid && ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_extra_beat got=%0h exp=none", data); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin bad++; $display("FAIL bp_data got=%0h exp=%0h", data, e); end
        end
        beats++;
      end
      if (done) dones++;
      cyc++;
      step_cycle();
    end
    total++; if (dones != 1) begin bad++; $display("FAIL bp_done got=%0d exp=1 (cycle budget)", dones); end
    total++; if (beats != MAXC) begin bad++; $display("FAIL bp_beats got=%0d exp=%0d", beats, MAXC); end
    total++; if (sent_count !== 16'(MAXC)) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", sent_count, MAXC); end
    ready = 1'b0;
  endtask

  task automatic test_early_stop();
    int n;
    n = $urandom_range(1, 4);
    ready = 1'b1;
    stop  = 1'b0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (valid !== 1'b1 || data !== beat_value(k)) begin bad++; $display("FAIL stop_pre_beat got=%0b/%0h exp=1/%0h", valid, data, beat_value(k)); end
      step_cycle();
    end
    ready = 1'b0;
    stop  = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b1 || data !== beat_value(3)) begin bad++; $display("FAIL stop_stall got=%0b/%0h exp=1/%0h", valid, data, beat_value(3)); end
    step_cycle();
    stop = 1'b0;
    for (int k = 1; k < n; k++) begin
      @(negedge clk);
      total++; if (valid !== 1'b1 || data !== beat_value(3)) begin bad++; $display("FAIL stop_pending_hold got=%0b/%0h exp=1/%0h", valid, data, beat_value(3)); end
      step_cycle();
    end
    ready = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b1 || data !== beat_value(3)) begin bad++; $display("FAIL stop_final_beat got=%0b/%0h exp=1/%0h", valid, data, beat_value(3)); end
    step_cycle();
    @(negedge clk);
    total++; if (valid !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL stop_done got=valid%0b/done%0b exp=valid0/done1", valid, done); end
    total++; if (sent_count !== 16'd4) begin bad++; $display("FAIL stop_count got=%0d exp=4", sent_count); end
    step_cycle();
    @(negedge clk);
    total++; if (valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL stop_idle got=valid%0b/done%0b exp=0/0", valid, done); end
    step_cycle();
    ready = 1'b0;
  endtask

  task automatic test_wrap();
    int dones = 0;
    int cyc = 0;
    int beats = 0;
    exp_w_q.delete();
    for (int i = 0; i < 4; i++) exp_w_q.push_back(wrap_value(i));
    stop = 1'b0;
    start_w = 1'b1;
    step_cycle();
    start_w = 1'b0;
    while (cyc < 100 && dones == 0) begin
      ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (valid_w && ready) begin
        total++;
        if (exp_w_q.size() == 0) begin bad++; $display("FAIL wrap_extra_beat got=%0d exp=none", data_w); end
        else begin
          logic [3:0] e;
          e = exp_w_q.pop_front();
          if (data_w !== e) begin bad++; $display("FAIL wrap_data got=%0d exp=%0d", data_w, e); end
        end
        beats++;
      end
      if (done_w) begin
        dones++;
        total++; if (valid_w !== 1'b0) begin bad++; $display("FAIL wrap_done_valid got=%0b exp=0", valid_w); end
      end
      cyc++;
      step_cycle();
    end
    total++; if (dones != 1) begin bad++; $display("FAIL wrap_done got=%0d exp=1 (cycle budget)", dones); end
    total++; if (beats != 4 || cnt_w !== 16'd4) begin bad++; $display("FAIL wrap_count got=%0d/%0d exp=4/4", beats, cnt_w); end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      int beats = 0;
      int cyc = 0;
      logic pend = 1'b0;
      logic expect_done = 1'b0;
      logic finished = 1'b0;
      stop = 1'b0;
      pulse_start();
      while (cyc < 200 && !finished) begin
        ready = 1'($urandom_range(0, 1));
        stop  = ($urandom_range(0, 7) == 0);
        @(negedge clk);
        if (expect_done) begin
          total++; if (done !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL b2b_done burst=%0d got=done%0b/valid%0b exp=1/0", b, done, valid); end
          total++; if (sent_count !== 16'(beats)) begin bad++; $display("FAIL b2b_count burst=%0d got=%0d exp=%0d", b, sent_count, beats); end
          finished = 1'b1;
        end else begin
          total++; if (done !== 1'b0 || valid !== 1'b1) begin bad++; $display("FAIL b2b_in_burst burst=%0d got=done%0b/valid%0b exp=0/1", b, done, valid); end
          if (stop) pend = 1'b1;
          if (valid && ready) begin
            total++; if (data !== beat_value(beats)) begin bad++; $display("FAIL b2b_data burst=%0d got=%0h exp=%0h", b, data, beat_value(beats)); end
            beats++;
            if (beats == MAXC || pend) expect_done = 1'b1;
          end
        end
        cyc++;
        step_cycle();
      end
      total++; if (!finished) begin bad++; $display("FAIL b2b_timeout burst=%0d got=unfinished exp=finished", b); end
    end
    stop  = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    int dones = 0;
    ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (data !== beat_value(k)) begin bad++; $display("FAIL mid_pre_beat got=%0h exp=%0h", data, beat_value(k)); end
      step_cycle();
    end
    ready = 1'b0;
    @(negedge clk);
    total++; if (valid !== 1'b1 || data !== 32'd8) begin bad++; $display("FAIL mid_stalled got=%0b/%0h exp=1/8", valid, data); end
    step_cycle();
    reset = 1'b0;
    step_cycle();
    reset = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b0 || data !== 32'd0) begin bad++; $display("FAIL mid_reset_out got=%0b/%0h exp=0/0", valid, data); end
    total++; if (sent_count !== 16'd0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset_cnt got=%0d/done%0b exp=0/done0", sent_count, done); end
    for (int k = 0; k < 3; k++) begin
      step_cycle();
      @(negedge clk);
      total++; if (done !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL mid_no_done got=done%0b/valid%0b exp=0/0", done, valid); end
    end
    step_cycle();
    ready = 1'b1;
    pulse_start();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (valid && ready) begin
        total++; if (data !== beat_value(beats)) begin bad++; $display("FAIL mid_restart_data got=%0h exp=%0h", data, beat_value(beats)); end
        beats++;
      end
      if (done) dones++;
      step_cycle();
    end
    total++; if (beats != MAXC || dones != 1 || sent_count !== 16'(MAXC)) begin bad++; $display("FAIL mid_restart got=beats%0d/done%0d/cnt%0d exp=%0d/1/%0d", beats, dones, sent_count, MAXC, MAXC); end
    ready = 1'b0;
  endtask

  task automatic test_ignored();
    int beats = 0;
    int dones = 0;
    int cyc = 0;
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (valid !== 1'b0 || done !== 1'b0 || sent_count !== 16'(MAXC)) begin bad++; $display("FAIL idle_stop got=%0b/%0b/%0d exp=0/0/%0d", valid, done, sent_count, MAXC); end
      step_cycle();
    end
    stop  = 1'b0;
    ready = 1'b0;
    pulse_start();
    @(negedge clk);
    total++; if (valid !== 1'b1 || data !== 32'd0) begin bad++; $display("FAIL ign_first got=%0b/%0h exp=1/0", valid, data); end
    step_cycle();
    start = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b1 || data !== 32'd0 || sent_count !== 16'd0) begin bad++; $display("FAIL ign_start_send got=%0b/%0h/%0d exp=1/0/0", valid, data, sent_count); end
    step_cycle();
    ready = 1'b1;
    while (cyc < 30 && dones == 0) begin
      @(negedge clk);
      if (valid && ready) begin
        total++; if (data !== beat_value(beats)) begin bad++; $display("FAIL ign_data got=%0h exp=%0h", data, beat_value(beats)); end
        beats++;
      end
      if (done) dones++;
      cyc++;
      step_cycle();
    end
    start = 1'b0;
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ign_start_done got=%0b exp=0", valid); end
    total++; if (beats != MAXC || dones != 1) begin bad++; $display("FAIL ign_burst got=beats%0d/done%0d exp=%0d/1", beats, dones, MAXC); end
    step_cycle();
    start_o = 1'b1;
    step_cycle();
    start_o = 1'b0;
    @(negedge clk);
    total++; if (valid_o !== 1'b1 || data_o !== 32'd0) begin bad++; $display("FAIL one_beat got=%0b/%0h exp=1/0", valid_o, data_o); end
    step_cycle();
    stop = 1'b1;
    @(negedge clk);
    total++; if (valid_o !== 1'b0 || done_o !== 1'b1 || cnt_o !== 16'd1) begin bad++; $display("FAIL one_done got=%0b/%0b/%0d exp=0/1/1", valid_o, done_o, cnt_o); end
    step_cycle();
    stop = 1'b0;
    @(negedge clk);
    total++; if (valid_o !== 1'b0 || done_o !== 1'b0 || cnt_o !== 16'd1) begin bad++; $display("FAIL one_idle got=%0b/%0b/%0d exp=0/0/1", valid_o, done_o, cnt_o); end
    step_cycle();
    ready = 1'b0;
  endtask

  initial begin
    #1;
    reset = 1'b0; start = 1'b0; start_w = 1'b0; start_o = 1'b0;
    stop = 1'b0; ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_early_stop();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/num_stream_tx.md
Name: num_stream_tx

Overview:
- Producer side of the even-number checking flow: emits an arithmetic number sequence (0, STEP, 2*STEP, …) over a valid/ready handshake to a downstream consumer or concurrent-assertion monitor.
- Sits in the testbench/verification fabric as the stimulus source; a bound SVA checker observes its output stream.
- Runs a burst of MAX_COUNT beats per start, then pulses done.

Parameters:
- WIDTH, 32, width of data output and internal value register.
- STEP, 2, increment between consecutive beats (even STEP gives an all-even stream).
- MAX_COUNT, 10, beats per burst; legal range 1..2^16-1.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- start  input  1  burst request; honoured only in IDLE.
- stop  input  1  early-termination request; honoured in SEND.
- ready  input  1  consumer accepts the beat when high together with valid.
- valid  output  1  data holds a beat.
- data  output  WIDTH  current sequence value.
- done  output  1  one-cycle pulse after the final beat is accepted.
- sent_count  output  16  beats accepted in the current or most recent burst.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; valid=0, data=0, done=0, sent_count=0, stop_pend=0 at the next edge. Reset mid-burst aborts immediately with no handshake completion.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - start=1 → next edge: state=SEND, valid=1, data=0, sent_count=0, stop_pend=0. Latency start→valid is 1 cycle.
  - start=0 → remain in IDLE; valid=0.
- SEND:
  - Beat transfers when valid&&ready at posedge. On transfer: sent_count+=1, data+=STEP (modulo 2^WIDTH, wrap silently).
  - While valid&&!ready, data and valid hold stable; valid never drops without a transfer.
  - Last beat: a transfer with sent_count+1==MAX_COUNT or stop_pend=1 → next edge: valid=0, state=DONE.
  - stop=1 in SEND sets stop_pend; the in-flight beat still completes.
  - stop and transfer in the same cycle count as last beat.
  - start is ignored in SEND and DONE.
- DONE: done=1 for exactly one cycle, valid=0, then IDLE. sent_count holds its final value until the next start.
- Boundary cases:
  - MAX_COUNT=1: exactly one beat (data=0), then DONE.
  - ready held high: one beat per cycle, no bubbles.
  - ready never asserted: stays in SEND indefinitely with data stable.
  - stop asserted in IDLE or DONE: no effect.
- All outputs are registered; no combinational path from ready to valid or data.

Decomposition:
- Shared package num_stream_pkg:
  - state_t enum {IDLE, SEND, DONE}.
  - Localparam defaults DEF_WIDTH=32, DEF_STEP=2, DEF_MAX_COUNT=10.
  - CNT_W=16.
- Sub-module num_stream_sva, bound onto the block, holds the concurrent properties:
  - valid&&!ready |=> $stable(data)&&valid.
  - (valid, STEP even) |-> data%2==0.
  - done |-> !valid.
  - done |=> !done.
- RTL core is a single module.

Test Plan:
- Basic burst: reset low 2 cycles, start pulse, ready=1 → valid from cycle after start, data 0,2,4,…,18 on 10 consecutive cycles; done pulses once; sent_count=10.
- Backpressure: ready toggles 1,0,0,1,… → data holds across stalled cycles; values remain 0,2,4,… with no skips or repeats; SVA stable-property passes.
- Early stop: stop=1 while data=6 and ready=0, then ready=1 → beat 6 transfers, valid drops, done pulses, sent_count=4.
- Wrap: WIDTH=4, STEP=6, MAX_COUNT=4 → data 0,6,12,2; done after the 4th beat.
- Reset mid-burst: reset=0 while data=8 → next edge valid=0, data=0, sent_count=0, no done; a fresh start restarts from 0.
- Ignored inputs: start during SEND and stop in IDLE → no state change; MAX_COUNT=1 burst emits a single data=0 beat.
